// File: rtl/upd_1771c.sv
// upd_1771c: uPD1771C-style sound generator, byte-packet host interface with DSB handshake and square-wave tone output.
module upd_1771c #(
  parameter int PRESCALE  = 32,
  parameter int DSB_DELAY = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CH1,
  input  logic       CH2,
  input  logic [7:0] PA_I,
  output logic [7:0] PA_O,
  output logic [7:0] PA_OE,
  input  logic [7:0] PB_I,
  output logic [7:0] PB_O,
  output logic [7:0] PB_OE,
  output logic [7:0] SOUND
);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DSB_DELAY + 1);
  typedef enum logic [1:0] {IDLE, TONE1, TONE2, TONE3} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, prev_q, acc, commit, pwrap;
  logic [DW-1:0] dly_q, dly_d;
  logic dsb_q, dsb_d;
  logic pen_q, pen_d, en_q, en_d, phase_q, phase_d;
  logic [7:0] pper_q, pper_d, per_q, per_d, cnt_q, cnt_d, sound_q, sound_d;
  logic [4:0] vol_q, vol_d;
  logic [PW-1:0] pre_q, pre_d;
  logic unused_straps;
  assign unused_straps = ^{CH1, CH2, PB_I[5:0]};
  always_comb begin
    acc = s2_q & ~prev_q;
    state_d = state_q;
    pen_d = pen_q;
    pper_d = pper_q;
    en_d = en_q;
    per_d = per_q;
    vol_d = vol_q;
    commit = 1'b0;
    if (acc)
      case (state_q)
        IDLE: begin
          state_d = PA_I == 8'h02 ? TONE1 : IDLE;
          en_d = PA_I == 8'h00 ? 1'b0 : en_q;
        end
        TONE1: begin
          pen_d = PA_I[7];
          state_d = TONE2;
        end
        TONE2: begin
          pper_d = PA_I;
          state_d = TONE3;
        end
        default: begin
          en_d = pen_q;
          per_d = pper_q;
          vol_d = PA_I[4:0];
          commit = 1'b1;
          state_d = IDLE;
        end
      endcase
    // DSB only rises while a packet is still waiting for bytes
    dly_d = s2_q ? '0 : (dly_q == DW'(DSB_DELAY) ? dly_q : dly_q + 1'b1);
    dsb_d = acc ? 1'b0 : dsb_q | (state_q != IDLE && dly_d == DW'(DSB_DELAY));
    pwrap = pre_q == PW'(PRESCALE - 1);
    pre_d = commit ? '0 : en_q ? (pwrap ? '0 : pre_q + 1'b1) : pre_q;
    cnt_d = commit ? '0 : (en_q && pwrap) ? (cnt_q == per_q ? 8'h00 : cnt_q + 8'h01) : cnt_q;
    phase_d = commit ? 1'b1 : (en_q && pwrap && cnt_q == per_q) ? ~phase_q : phase_q;
    sound_d = (!en_q || vol_q == 5'd0) ? 8'h80 :
              phase_q ? 8'h80 + {1'b0, vol_q, 2'b00} : 8'h80 - {1'b0, vol_q, 2'b00};
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
      state_q <= IDLE;
      dly_q <= '0;
      dsb_q <= 1'b0;
      pen_q <= 1'b0;
      pper_q <= 8'h00;
      en_q <= 1'b0;
      per_q <= 8'h00;
      vol_q <= 5'd0;
      pre_q <= '0;
      cnt_q <= 8'h00;
      phase_q <= 1'b0;
      sound_q <= 8'h80;
    end else begin
      s1_q <= ~PB_I[7] & ~PB_I[6];
      s2_q <= s1_q;
      prev_q <= s2_q;
      state_q <= state_d;
      dly_q <= dly_d;
      dsb_q <= dsb_d;
      pen_q <= pen_d;
      pper_q <= pper_d;
      en_q <= en_d;
      per_q <= per_d;
      vol_q <= vol_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      sound_q <= sound_d;
    end
  end
  assign PA_O = 8'h00;
  assign PA_OE = 8'h00;
  assign PB_O = {7'b0, dsb_q};
  assign PB_OE = 8'h01;
  assign SOUND = sound_q;
endmodule

// File: tb/tb_upd_1771c.sv
// tb_upd_1771c: packet handshake vectors plus a SOUND transition scoreboard for upd_1771c.
module tb_upd_1771c;
  localparam int DD = 16;
  logic CLK = 1'b0, RES = 1'b1, CH1 = 1'b0, CH2 = 1'b0;
  logic [7:0] PA_I = 8'h00, PB_I = 8'hFF;
  logic [7:0] PA_O, PA_OE, PB_O, PB_OE, SOUND;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [7:0] val; int gap; bit exact;} snd_t;
  typedef struct {logic [7:0] d; logic dsb;} vec_t;
  snd_t exp_q[$];
  vec_t tv[4];
  logic [7:0] s6;
  upd_1771c dut (.CLK(CLK), .RES(RES), .CH1(CH1), .CH2(CH2), .PA_I(PA_I), .PA_O(PA_O), .PA_OE(PA_OE),
                 .PB_I(PB_I), .PB_O(PB_O), .PB_OE(PB_OE), .SOUND(SOUND));
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic push(input logic [7:0] v, input int g, input bit ex);
    snd_t e;
    e.val = v;
    e.gap = g;
    e.exact = ex;
    exp_q.push_back(e);
  endtask
  task automatic write_byte(input logic [7:0] d, input logic exp_dsb, output logic [7:0] snd6);
    int k;
    logic seen;
    PA_I = d;
    PB_I = 8'h3F;
    repeat (4) @(negedge CLK);
    chk($sformatf("dsb_fall_%02h", d), PB_O[0], 0);
    repeat (2) @(negedge CLK);
    snd6 = SOUND;
    repeat (2) @(negedge CLK);
    PB_I = 8'hFF;
    if (exp_dsb) begin
      k = 0;
      while (k < DD + 10 && !PB_O[0]) begin
        @(negedge CLK);
        k++;
      end
      chk($sformatf("dsb_rise_lat_%02h", d), k, DD + 2);
    end else begin
      seen = 1'b0;
      repeat (DD + 6) begin
        @(negedge CLK);
        seen |= PB_O[0];
      end
      chk($sformatf("dsb_stay0_%02h", d), seen, 0);
    end
  endtask
  task automatic drain(input int lim);
    int k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(negedge CLK);
      k++;
    end
    chk("snd_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    tv[0] = '{8'h02, 1'b1};
    tv[1] = '{8'h80, 1'b1};
    tv[2] = '{8'h35, 1'b1};
    tv[3] = '{8'h15, 1'b0};
    repeat (12) @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    chk("rst_dsb", PB_O, 8'h00);
    chk("rst_sound", SOUND, 8'h80);
    chk("rst_pb_oe", PB_OE, 8'h01);
    chk("rst_pa_oe", PA_OE, 8'h00);
    chk("rst_pa_o", PA_O, 8'h00);
    fork
      begin
        logic [7:0] last;
        int gap;
        snd_t e;
        last = 8'h80;
        gap = 0;
        forever begin
          @(negedge CLK);
          gap++;
          if (SOUND !== last) begin
            if (exp_q.size() == 0) chk("snd_unexpected", SOUND, last);
            else begin
              e = exp_q.pop_front();
              chk("snd_val", SOUND, e.val);
              if (e.gap >= 0) begin
                if (e.exact) chk("snd_half_period", gap, e.gap);
                else chk("snd_gap_within", gap <= e.gap, 1);
              end
            end
            last = SOUND;
            gap = 0;
          end
        end
      end
    join_none
    // first tone: P=0x35, V=0x15 -> 0xD4/0x2C, half period 1728
    push(8'hD4, -1, 1'b0);
    push(8'h2C, 1728, 1'b1);
    push(8'hD4, 1728, 1'b1);
    for (int i = 0; i < 4; i++) write_byte(tv[i].d, tv[i].dsb, s6);
    drain(4000);
    push(8'h2C, 1728, 1'b1);
    drain(2000);
    // retune from the low phase: commit forces phase high before the old tone toggles
    push(8'hD4, 1727, 1'b0);
    push(8'h2C, 2560, 1'b1);
    push(8'hD4, 2560, 1'b1);
    write_byte(8'h02, 1'b1, s6);
    write_byte(8'h80, 1'b1, s6);
    write_byte(8'h4F, 1'b1, s6);
    chk("retune_hold_old", SOUND, 8'h2C);
    write_byte(8'h15, 1'b0, s6);
    drain(6000);
    push(8'h80, -1, 1'b0);
    write_byte(8'h00, 1'b0, s6);
    chk("silence_fast", s6, 8'h80);
    write_byte(8'h7E, 1'b0, s6);
    chk("unknown_cmd_sound", SOUND, 8'h80);
    drain(10);
    write_byte(8'h02, 1'b1, s6);
    write_byte(8'h80, 1'b1, s6);
    RES = 1'b1;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    chk("midrst_dsb", PB_O[0], 0);
    write_byte(8'h02, 1'b1, s6);
    write_byte(8'h00, 1'b1, s6);
    write_byte(8'h10, 1'b1, s6);
    write_byte(8'h1F, 1'b0, s6);
    repeat (300) @(negedge CLK);
    chk("midrst_sound", SOUND, 8'h80);
    chk("midrst_no_change", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
